// File: rtl/fpu_result_collector.sv
// fpu_result_collector
// Collects results from one add_sub and one mul FPU through their
// v_o/z_o/yumi_i handshakes. Both sources share one round-robin arbiter.
// Each result is tagged with its source and its exception flags, buffered
// in a small FIFO, and presented on a single valid/ready output stream.
// A saturating counter tracks how many buffered results raised exceptions.
//
// Optional build macro: FPU_COLLECT_NAN_CANON_EN
//   When defined, a result whose invalid flag is set is stored as the
//   canonical quiet NaN instead of the value the FPU produced.
//   The flags and the exception counter are not affected.
module fpu_result_collector #(
    parameter int E_P   = 8,
    parameter int M_P   = 23,
    parameter int DEPTH = 4,
    localparam int W     = E_P + M_P + 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             add_v_i,
    input  logic [W-1:0]     add_z_i,
    input  logic [3:0]       add_flags_i,
    output logic             add_yumi_o,
    input  logic             mul_v_i,
    input  logic [W-1:0]     mul_z_i,
    input  logic [3:0]       mul_flags_i,
    output logic             mul_yumi_o,
    output logic             v_o,
    output logic [W-1:0]     z_o,
    output logic             src_o,
    output logic [3:0]       flags_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic [15:0]      err_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = W + 5;   // {src, flags[3:0], z}
    localparam logic [W-1:0] QNAN = {1'b0, {E_P{1'b1}}, 1'b1, {(M_P-1){1'b0}}};

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_err_cnt;
    logic             r_prefer_mul;   // 0: add wins a tie, 1: mul wins a tie

    logic             w_space;
    logic             w_add_yumi;
    logic             w_mul_yumi;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_flags;
    logic [W-1:0]     w_z_raw;
    logic [W-1:0]     w_z;
    logic [ENT_W-1:0] w_push_entry;
    logic [ENT_W-1:0] w_rd_entry;

    // Space is judged on registered occupancy. A pop in the same cycle
    // therefore never opens a slot for a new push.
    assign w_space = (r_count < CNT_W'(DEPTH));

    // Round-robin grant. At most one yumi is asserted, and a yumi is only
    // asserted with its valid. Reset forces both low at once, because the
    // FPUs must not dequeue while the collector is being cleared.
    always_comb begin
        w_add_yumi = 1'b0;
        w_mul_yumi = 1'b0;
        if (reset_n_i && w_space) begin
            if (add_v_i && mul_v_i) begin
                w_mul_yumi = r_prefer_mul;
                w_add_yumi = ~r_prefer_mul;
            end else begin
                w_add_yumi = add_v_i;
                w_mul_yumi = mul_v_i;
            end
        end
    end

    assign add_yumi_o = w_add_yumi;
    assign mul_yumi_o = w_mul_yumi;
    assign w_push     = w_add_yumi | w_mul_yumi;
    assign w_pop      = (r_count != '0) & ready_i;

    assign w_flags = w_mul_yumi ? mul_flags_i : add_flags_i;
    assign w_z_raw = w_mul_yumi ? mul_z_i     : add_z_i;

`ifdef FPU_COLLECT_NAN_CANON_EN
    assign w_z = w_flags[2] ? QNAN : w_z_raw;
`else
    assign w_z = w_z_raw;
`endif

    assign w_push_entry = {w_mul_yumi, w_flags, w_z};

    // FIFO storage. Entries reset to zero so that the output fields read 0
    // while the collector is held in reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i)
                    r_mem[gi] <= '0;
                else if (w_push && (r_wr_ptr == PTR_W'(gi)))
                    r_mem[gi] <= w_push_entry;
            end
        end
    endgenerate

    // Pointers, occupancy and the arbiter's tie-break state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_prefer_mul <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // The tie-break flips only on a real grant, toward the other source.
            if (w_push)
                r_prefer_mul <= w_add_yumi;
        end
    end

    // Saturating count of pushed results that carry any exception flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_err_cnt <= '0;
        else if (w_push && (w_flags != 4'b0000) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign w_rd_entry = r_mem[r_rd_ptr];
    assign v_o        = (r_count != '0);
    assign z_o        = w_rd_entry[W-1:0];
    assign flags_o    = w_rd_entry[W+3:W];
    assign src_o      = w_rd_entry[W+4];
    assign count_o    = r_count;
    assign err_cnt_o  = r_err_cnt;

endmodule
